mantissa_aligner: RTL and testbench

MANTISSA_ALIGNER -- requirements
Module: mantissa_aligner

---
 rtl/mantissa_aligner.sv | 163 ++++++++++++++++
 tb/tb_mantissa_aligner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_aligner.sv
// mantissa_aligner
// Right-aligns a 24-bit mantissa with its hidden 1 at bit 23. This is the
// alignment step of a floating-point adder: the mantissa of the smaller
// operand is shifted right by the exponent difference.
//
// The shift runs over several cycles, at most 4 bit positions per cycle.
// The datapath works on a 26-bit register {mantissa, guard, round}. Every
// bit shifted out of the bottom of that register is ORed into a sticky
// accumulator. The result registers change only when an operation
// completes, and they hold their values between completions.
//
// Latency: the start is accepted at edge N. done is high in cycle
// N + max(1, ceil(k/4)) + 1, where k = min(shift_amt, 26).

module mantissa_aligner (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] mantissa_in,
  input  logic [7:0]  shift_amt,
  output logic [23:0] mantissa_out,
  output logic        guard,
  output logic        round_bit,
  output logic        sticky,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A shift of 26 positions empties the work register, so no count needs
  // to go above 26.
  localparam logic [4:0] MAX_SHIFT = 5'd26;
  localparam logic [2:0] MAX_STEP  = 3'd4;

  state_t      state_q, state_d;
  logic [25:0] work_q, work_d;
  logic [4:0]  remaining_q, remaining_d;
  logic        acc_q, acc_d;
  logic [23:0] mant_q, mant_d;
  logic        guard_q, guard_d;
  logic        round_q, round_d;
  logic        sticky_q, sticky_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Per-cycle shift step and the bits that this step drops off the bottom
  logic [2:0]  step;
  logic [3:0]  lost_mask;
  logic [25:0] work_shifted;
  logic        lost_any;

  // Shift step for this cycle: min(remaining, 4), and the mask of the bits it drops
  always_comb begin
    step = (remaining_q > {2'b00, MAX_STEP}) ? MAX_STEP : remaining_q[2:0];
    unique case (step)
      3'd0:    lost_mask = 4'b0000;
      3'd1:    lost_mask = 4'b0001;
      3'd2:    lost_mask = 4'b0011;
      3'd3:    lost_mask = 4'b0111;
      default: lost_mask = 4'b1111;
    endcase
    work_shifted = work_q >> step;
    lost_any     = |(work_q[3:0] & lost_mask);
  end

  // Next-state and next-output logic for the IDLE -> SHIFT -> DONE sequence
  always_comb begin
    // NOTE: every signal written here is given a default from its flop
    // first. If one branch did not assign a signal, synthesis would infer
    // a latch for it.
    state_d     = state_q;
    work_d      = work_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    mant_d      = mant_q;
    guard_d     = guard_q;
    round_d     = round_q;
    sticky_d    = sticky_q;

    unique case (state_q)
      IDLE: begin
        // start and the operands are sampled only here. Later changes to
        // the inputs cannot reach the operation in flight.
        if (start) begin
          work_d      = {mantissa_in, 2'b00};
          acc_d       = 1'b0;
          remaining_d = (shift_amt > {3'b000, MAX_SHIFT}) ? MAX_SHIFT : shift_amt[4:0];
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        work_d      = work_shifted;
        acc_d       = acc_q | lost_any;
        remaining_d = remaining_q - {2'b00, step};
        // A count of zero still spends one SHIFT cycle, with step = 0.
        if (remaining_d == 5'd0) begin
          state_d  = DONE;
          mant_d   = work_shifted[25:2];
          guard_d  = work_shifted[1];
          round_d  = work_shifted[0];
          sticky_d = acc_q | lost_any;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // busy and done are decoded from the next state, so the flops hold
    // them in step with the state register.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers. Reset is asynchronous and aborts
  // any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      remaining_q <= '0;
      acc_q       <= 1'b0;
      mant_q      <= '0;
      guard_q     <= 1'b0;
      round_q     <= 1'b0;
      sticky_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here. Every flop samples its _d
      // value from before this edge, whatever order the lines are in.
      state_q     <= state_d;
      work_q      <= work_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      mant_q      <= mant_d;
      guard_q     <= guard_d;
      round_q     <= round_d;
      sticky_q    <= sticky_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mantissa_out = mant_q;
  assign guard        = guard_q;
  assign round_bit    = round_q;
  assign sticky       = sticky_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mantissa_aligner.sv
// tb_mantissa_aligner
// The stimulus tasks push an expected result to a scoreboard queue when a
// start is accepted. wait_result pops that entry when done shows and
// compares the data, G/R/S and the latency against it. The reference model
// shifts in one wide step. The DUT shifts in steps of up to 4 bits.

module tb_mantissa_aligner;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] mantissa_in;
  logic [7:0]  shift_amt;
  logic [23:0] mantissa_out;
  logic        guard;
  logic        round_bit;
  logic        sticky;
  logic        busy;
  logic        done;

  typedef struct {
    logic [23:0] m;
    logic        g;
    logic        r;
    logic        s;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   checks;
  int   failures;

  mantissa_aligner dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mantissa_in  (mantissa_in),
    .shift_amt    (shift_amt),
    .mantissa_out (mantissa_out),
    .guard        (guard),
    .round_bit    (round_bit),
    .sticky       (sticky),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: place the whole value in a 52-bit field and shift it
  // once. The 26 bits below the work register feed sticky.
  function automatic exp_t model(input logic [23:0] m, input logic [7:0] sa);
    exp_t        e;
    logic [51:0] full;
    int          k;
    k      = (sa > 8'd26) ? 26 : int'(sa);
    full   = {m, 2'b00, 26'd0} >> k;
    e.m    = full[51:28];
    e.g    = full[27];
    e.r    = full[26];
    e.s    = |full[25:0];
    e.lat  = ((k == 0) ? 1 : (k + 3) / 4) + 1;
    return e;
  endfunction

  // Build an expected entry from literal values
  function automatic exp_t mk(input logic [23:0] m, input logic g, input logic r,
                              input logic s, input int lat);
    exp_t e;
    e.m = m; e.g = g; e.r = r; e.s = s; e.lat = lat;
    return e;
  endfunction

  // Drive one start with DUT idle; it is accepted on the next posedge
  task automatic issue(input logic [23:0] m, input logic [7:0] sa, input exp_t e, input bit hold);
    @(negedge clk);
    mantissa_in = m;
    shift_amt   = sa;
    start       = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Call #1 after the accept edge. Waits for done (bounded), pops the
  // scoreboard and compares. Latency counts the cycles after the accept edge.
  task automatic wait_result(input string name);
    int   lat;
    bit   found;
    exp_t e;
    lat   = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end
      end
      if (done === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    last_exp = e;
    checks += 4;
    if (lat !== e.lat) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
    end
    if (mantissa_out !== e.m) begin
      failures++;
      $display("FAIL %s mantissa_out: got %h want %h", name, mantissa_out, e.m);
    end
    if ({guard, round_bit, sticky} !== {e.g, e.r, e.s}) begin
      failures++;
      $display("FAIL %s grs: got %b%b%b want %b%b%b", name, guard, round_bit, sticky,
               e.g, e.r, e.s);
    end
    @(negedge clk);
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL %s done_single_cycle: got done=%b busy=%b want 0/0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mantissa_in = 24'hABCDEF;
    shift_amt = 8'd5;
    repeat (3) @(posedge clk);
    #2;
    checks += 3;
    if (mantissa_out !== 24'h0) begin
      failures++;
      $display("FAIL reset mantissa_out: got %h want 000000", mantissa_out);
    end
    if ({guard, round_bit, sticky} !== 3'b000) begin
      failures++;
      $display("FAIL reset grs: got %b%b%b want 000", guard, round_bit, sticky);
    end
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset busy_done: got %b%b want 00", busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_spec_vectors();
    issue(24'h800000, 8'd0,  mk(24'h800000, 1'b0, 1'b0, 1'b0, 2), 1'b0);
    wait_result("vec_shift0");
    issue(24'h800007, 8'd3,  mk(24'h100000, 1'b1, 1'b1, 1'b1, 2), 1'b0);
    wait_result("vec_shift3");
    issue(24'hC00001, 8'd9,  mk(24'h006000, 1'b0, 1'b0, 1'b1, 4), 1'b0);
    wait_result("vec_shift9");
    issue(24'hFFFFFF, 8'd40, mk(24'h000000, 1'b0, 1'b0, 1'b1, 8), 1'b0);
    wait_result("vec_shift40");
    issue(24'hFFFFFF, 8'd25, mk(24'h000000, 1'b0, 1'b1, 1'b1, 8), 1'b0);
    wait_result("vec_shift25");
    issue(24'h000000, 8'd7,  mk(24'h000000, 1'b0, 1'b0, 1'b0, 3), 1'b0);
    wait_result("vec_zero_mant");
    issue(24'h800001, 8'd255, model(24'h800001, 8'd255), 1'b0);
    wait_result("vec_shift255");
    issue(24'hFFFFFF, 8'd4, model(24'hFFFFFF, 8'd4), 1'b0);
    wait_result("vec_shift4");
  endtask

  task automatic test_random();
    logic [23:0] m;
    logic [7:0]  sa;
    for (int i = 0; i < 10; i++) begin
      m  = {1'b1, 23'($urandom)};
      sa = 8'($urandom_range(0, 30));
      issue(m, sa, model(m, sa), 1'b0);
      wait_result($sformatf("rand%0d", i));
    end
  endtask

  // With no start, the outputs keep the last result while the inputs change
  task automatic test_hold_outputs();
    exp_t e;
    e = last_exp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mantissa_in = 24'($urandom);
      shift_amt   = 8'($urandom);
    end
    @(negedge clk);
    checks++;
    if ({mantissa_out, guard, round_bit, sticky, busy} !== {e.m, e.g, e.r, e.s, 1'b0}) begin
      failures++;
      $display("FAIL hold_outputs: got %h/%b%b%b busy=%b want %h/%b%b%b busy=0",
               mantissa_out, guard, round_bit, sticky, busy, e.m, e.g, e.r, e.s);
    end
  endtask

  // start held high while the inputs change: one done, original result.
  // Then a new accept is aborted by reset.
  task automatic test_start_held_and_abort();
    int saw_done;
    issue(24'hC00001, 8'd9, mk(24'h006000, 1'b0, 1'b0, 1'b1, 4), 1'b1);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          mantissa_in = 24'h812345 + 24'(i);
          shift_amt   = 8'd1;
        end
      end
      wait_result("held_start");
    join
    // start is still high. DUT is IDLE now, so a new accept happens at the next posedge.
    mantissa_in = 24'hF0F0F0;
    shift_amt   = 8'd20;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reaccept busy: got %b want 1", busy);
    end
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL abort_immediate: got busy=%b done=%b want 0/0", busy, done);
    end
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
    end
    // Release reset and raise start, so the first posedge after release accepts.
    mantissa_in = 24'hA00003;
    shift_amt   = 8'd6;
    start       = 1'b1;
    sb.push_back(model(24'hA00003, 8'd6));
    reset = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_result("after_reset");
    checks++;
    if (saw_done != 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d pulses want 0", saw_done);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    start       = 1'b0;
    mantissa_in = '0;
    shift_amt   = '0;
    test_reset();
    test_spec_vectors();
    test_random();
    test_hold_outputs();
    test_start_held_and_abort();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
